// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader states, frame marker and opcodes.
// Imported by the program loader and the program RAM.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_RUN,
    S_ERROR
  } ld_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LDI_R0 = 4'h1;
  localparam logic [3:0] OP_ADD_R0 = 4'h2;
  localparam logic [3:0] OP_OUT    = 4'h7;
  localparam logic [3:0] OP_HLT    = 4'hF;

  function automatic logic [7:0] csum_add(
    input logic [7:0] acc,
    input logic [7:0] b
  );
    return acc + b;
  endfunction

  function automatic logic in_frame(input ld_state_e s);
    return (s == S_LEN) || (s == S_DATA) || (s == S_CHK);
  endfunction

endpackage

// File: rtl/prog_ram.sv
// Program store: synchronous write, clear on reset, async read.
// The CPU fetches through the read port by PC address.
module prog_ram
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for the CPU program RAM.
// Holds the CPU in reset until a checksum-correct program is resident.
module prog_loader
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int unsigned       TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic              busy
);

  localparam int TMO_W = 16;
  localparam logic [DATA_W:0] DEPTH_L =
    (DATA_W+1)'(1 << ADDR_W);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] lm1_q, lm1_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              xfer;
  logic              is_sync;
  logic              len_ok;
  logic [DATA_W-1:0] len_m1;
  logic [TMO_W-1:0]  tmo_nxt;
  logic              tmo_hit;
  logic              we;

  assign in_ready = 1'b1;
  assign xfer     = in_valid & in_ready;
  assign is_sync  = (in_data == SYNC_BYTE);
  assign len_ok   = (in_data != '0) &&
                    ({1'b0, in_data} <= DEPTH_L);
  assign len_m1   = in_data - DATA_W'(1);
  assign tmo_nxt  = tmo_q + TMO_W'(1);
  assign tmo_hit  = (TIMEOUT != 0) &&
                    (tmo_nxt == TMO_W'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lm1_d       = lm1_q;
    sum_d       = sum_q;
    tmo_d       = '0;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    err_d       = err_q;
    we          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (xfer && is_sync) state_d = S_LEN;
      end
      S_LEN: begin
        if (xfer) begin
          if (len_ok) begin
            lm1_d   = len_m1[ADDR_W-1:0];
            cnt_d   = '0;
            sum_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          we    = 1'b1;
          sum_d = csum_add(sum_q, in_data);
          cnt_d = cnt_q + ADDR_W'(1);
          if (cnt_q == lm1_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d     = S_RUN;
            cpu_reset_d = 1'b0;
            done_d      = 1'b1;
            err_d       = 1'b0;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_RUN: begin
        if (xfer && is_sync) begin
          state_d     = S_LEN;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
        end
      end
      S_ERROR: begin
        if (xfer && is_sync) begin
          state_d = S_LEN;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Idle-gap watchdog only runs while a frame is open
    if (in_frame(state_q) && !xfer) begin
      tmo_d = tmo_nxt;
      if (tmo_hit) state_d = S_ERROR;
    end

    if (state_d == S_ERROR && state_q != S_ERROR) begin
      err_d       = 1'b1;
      cpu_reset_d = 1'b1;
      done_d      = 1'b0;
    end

    busy_d = in_frame(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lm1_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lm1_q       <= lm1_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (cnt_q),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign cpu_reset  = cpu_reset_q;
  assign load_done  = done_q;
  assign load_error = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances, long and short timeout.
// Inputs change #1 after posedge; outputs are checked before the next edge.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic [3:0] rd_addr;

  logic       in_ready, cpu_reset, load_done, load_error, busy;
  logic [7:0] rd_data;
  logic       t_ready, t_cpu_reset, t_done, t_err, t_busy;
  logic [7:0] t_rd_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  prog_loader #(.TIMEOUT(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .busy       (busy)
  );

  prog_loader #(.TIMEOUT(8)) dut_t (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (t_ready),
    .rd_addr    (rd_addr),
    .rd_data    (t_rd_data),
    .cpu_reset  (t_cpu_reset),
    .load_done  (t_done),
    .load_error (t_err),
    .busy       (t_busy)
  );

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [3:0] a,
                    input logic [7:0] exp);
    rd_addr = a;
    #1;
    check(tag, rd_data, exp);
  endtask

  task automatic send_frame(input int gap);
    logic [7:0] f [8];
    f = '{8'hA5, 8'h05, 8'h10, 8'h05,
          8'h20, 8'h70, 8'hF0, 8'h95};
    for (int i = 0; i < 8; i++) begin
      send(f[i]);
      if (gap > 0 && i < 7) idle(gap);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    rd_addr  = 4'h0;
    idle(2);
    reset = 1'b0;

    check("rst_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    check("rst_load_done", {7'b0, load_done}, 8'h00);
    check("rst_load_error", {7'b0, load_error}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_in_ready", {7'b0, in_ready}, 8'h01);
    rd("rst_ram0", 4'h0, 8'h00);

    // Normal back-to-back load
    send(8'hA5);
    send(8'h05);
    check("len_busy", {7'b0, busy}, 8'h01);
    send(8'h10); send(8'h05); send(8'h20);
    send(8'h70); send(8'hF0);
    check("pre_chk_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    send(8'h95);
    check("norm_done", {7'b0, load_done}, 8'h01);
    check("norm_cpu_reset", {7'b0, cpu_reset}, 8'h00);
    check("norm_busy", {7'b0, busy}, 8'h00);
    check("norm_t_done", {7'b0, t_done}, 8'h01);
    rd("norm_rd0", 4'h0, 8'h10);
    rd("norm_rd1", 4'h1, 8'h05);
    rd("norm_rd2", 4'h2, 8'h20);
    rd("norm_rd3", 4'h3, 8'h70);
    rd("norm_rd4", 4'h4, 8'hF0);
    rd("norm_rd5", 4'h5, 8'h00);

    // Gapped stream
    do_reset();
    send_frame(3);
    check("gap_done", {7'b0, load_done}, 8'h01);
    check("gap_cpu_reset", {7'b0, cpu_reset}, 8'h00);
    check("gap_t_done", {7'b0, t_done}, 8'h01);
    rd("gap_rd2", 4'h2, 8'h20);
    rd("gap_rd4", 4'h4, 8'hF0);

    // Reload hold, then bad checksum
    send(8'hA5);
    check("rl_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    check("rl_done", {7'b0, load_done}, 8'h00);
    send(8'h05); send(8'h10); send(8'h05);
    send(8'h20); send(8'h70); send(8'hF0);
    send(8'h94);
    check("badchk_err", {7'b0, load_error}, 8'h01);
    check("badchk_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    check("badchk_busy", {7'b0, busy}, 8'h00);

    send(8'hA5);
    check("err_sync_clear", {7'b0, load_error}, 8'h00);
    check("err_sync_busy", {7'b0, busy}, 8'h01);
    send(8'h00);
    check("len0_err", {7'b0, load_error}, 8'h01);
    send(8'hA5);
    send(8'h11);
    check("len11_err", {7'b0, load_error}, 8'h01);
    check("len11_done", {7'b0, load_done}, 8'h00);
    send_frame(0);
    check("recov_err", {7'b0, load_error}, 8'h00);
    check("recov_done", {7'b0, load_done}, 8'h01);

    // Stall after second data byte
    send(8'hA5); send(8'h05); send(8'h10); send(8'h05);
    idle(7);
    check("tmo_7_err", {7'b0, t_err}, 8'h00);
    check("tmo_7_busy", {7'b0, t_busy}, 8'h01);
    idle(1);
    check("tmo_8_err", {7'b0, t_err}, 8'h01);
    check("tmo_8_busy", {7'b0, t_busy}, 8'h00);
    check("tmo_8_cpu_reset", {7'b0, t_cpu_reset}, 8'h01);
    check("tmo_long_busy", {7'b0, busy}, 8'h01);
    check("tmo_long_err", {7'b0, load_error}, 8'h00);
    rd_addr = 4'h0; #1;
    check("tmo_rd0", t_rd_data, 8'h10);
    rd_addr = 4'h1; #1;
    check("tmo_rd1", t_rd_data, 8'h05);

    // Reload a 2-byte program over a resident one
    do_reset();
    send_frame(0);
    send(8'hA5);
    check("rl2_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    send(8'h02); send(8'hF0); send(8'h00); send(8'hF0);
    check("rl2_done", {7'b0, load_done}, 8'h01);
    check("rl2_cpu_reset_run", {7'b0, cpu_reset}, 8'h00);
    rd("rl2_rd0", 4'h0, 8'hF0);
    rd("rl2_rd1", 4'h1, 8'h00);
    rd("rl2_rd2", 4'h2, 8'h20);
    rd("rl2_rd3", 4'h3, 8'h70);
    rd("rl2_rd4", 4'h4, 8'hF0);

    // Reset mid-DATA with a concurrent transfer
    send(8'hA5); send(8'h05); send(8'h10); send(8'h05);
    reset    = 1'b1;
    in_data  = 8'h20;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check("mid_busy", {7'b0, busy}, 8'h00);
    check("mid_cpu_reset", {7'b0, cpu_reset}, 8'h01);
    check("mid_done", {7'b0, load_done}, 8'h00);
    for (int a = 0; a < 5; a++) begin
      rd($sformatf("mid_rd%0d", a), 4'(a), 8'h00);
    end
    send(8'h33); send(8'h05);
    check("junk_busy", {7'b0, busy}, 8'h00);
    send(8'hA5);
    check("junk_sync_busy", {7'b0, busy}, 8'h01);
    send(8'h01); send(8'h07); send(8'h07);
    check("junk_done", {7'b0, load_done}, 8'h01);
    rd("junk_rd0", 4'h0, 8'h07);
    rd("junk_rd1", 4'h1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Writer side of the CPU's 16x8 program store, replacing the fixed initial-block ROM with a loadable program RAM.
- Accepts a framed byte stream on a valid/ready interface and checks length and checksum.
- Writes the payload into program RAM, which the CPU reads combinationally by PC address.
- Holds the CPU in reset until a complete, checksum-correct program is resident.

Parameters:
ADDR_W, 4, program address width; depth = 2**ADDR_W (16)
DATA_W, 8, byte/instruction width
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT, 255, max idle cycles between bytes inside a frame; 0 disables the timeout

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_data  in  DATA_W  incoming stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader can accept a byte; transfer = in_valid & in_ready at rising clk
rd_addr  in  ADDR_W  CPU program-fetch address (PC)
rd_data  out  DATA_W  program byte at rd_addr, combinational
cpu_reset  out  1  hold CPU in reset (registered)
load_done  out  1  valid program resident, CPU running
load_error  out  1  last frame rejected
busy  out  1  frame in progress (states LEN/DATA/CHK)

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high; it wins over any simultaneous transfer.
- Reset values: state=IDLE, cpu_reset=1, load_done=0, load_error=0, busy=0, in_ready=1, all RAM words=8'h00 (NOP), byte counter=0, checksum=0, timeout counter=0.
- Frame format: SYNC_BYTE, LEN, LEN data bytes, CHK. CHK = 8-bit wrap-around sum of the data bytes.
- in_ready is 1 in every state. Every transfer is consumed; non-sync bytes in IDLE/RUN/ERROR are discarded.
- State IDLE: a transfer with in_data==SYNC_BYTE -> LEN.
- State LEN: accept LEN.
  - LEN in 1..2**ADDR_W: store it, clear count and checksum -> DATA.
  - LEN==0 or LEN>depth -> ERROR.
- State DATA: each transfer does mem[count] <= in_data, checksum += in_data (mod 256), count++.
  - When count reaches LEN-1 on the transfer -> CHK.
  - Words at addresses >= LEN are left unchanged.
- State CHK, transfer:
  - in_data==checksum -> RUN; same edge sets cpu_reset<=0, load_done<=1, load_error<=0.
  - Mismatch -> ERROR.
- State RUN: CPU executes.
  - A SYNC_BYTE transfer -> LEN; same edge sets cpu_reset<=1, load_done<=0 (CPU re-held before any write).
  - Other bytes are ignored.
- State ERROR: load_error=1, cpu_reset=1, load_done=0. RAM keeps any partial writes. A SYNC_BYTE transfer -> LEN and clears load_error.
- Timeout: in LEN/DATA/CHK, the counter increments on every cycle without a transfer and clears on each transfer. Reaching TIMEOUT -> ERROR on that edge. Not active when TIMEOUT==0.
- busy = (state in {LEN, DATA, CHK}); registered with state.
- Output timing: cpu_reset, load_done and load_error change only at the clock edge of the causing transfer. They are visible the following cycle.
- Read port: rd_data = mem[rd_addr], combinational, with no read/write hazard logic. A write becomes visible the cycle after its edge.
- Reset mid-frame: returns to IDLE, RAM cleared, CPU held.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum {IDLE, LEN, DATA, CHK, RUN, ERROR}
  - SYNC_BYTE default
  - the opcode constants used by the CPU (NOP=0, LDI_R0=1, ADD_R0=2, OUT=7, HLT=F)
- One sub-module, prog_ram: 2**ADDR_W x DATA_W array, synchronous write with sync reset-clear, asynchronous read.
- The FSM, counters and checksum stay in prog_loader.

Test Plan:
- Normal load: A5,05,10,05,20,70,F0,95 back-to-back.
  - Response: load_done=1 and cpu_reset=0 the cycle after the 95 byte.
  - rd_addr 0..4 read 10,05,20,70,F0; rd_addr 5 reads 00.
- Gapped stream: same frame with in_valid low 3 cycles between bytes, TIMEOUT=255 -> identical result.
- Error cases: bad checksum (last byte 94) -> load_error=1, cpu_reset=1. LEN=00 -> ERROR; LEN=11h -> ERROR. Then a valid frame -> load_error=0, load_done=1.
- Timeout: TIMEOUT=8, frame stalls after the 2nd data byte -> ERROR asserted exactly 8 idle cycles after the last transfer. Partial bytes are readable.
- Reload: in RUN send A5 -> cpu_reset=1 next cycle. A new 2-byte frame A5,02,F0,00,F0 overwrites addr0..1, leaves addr2..4 unchanged, and ends in RUN.
- Reset handling: reset asserted mid-DATA together with in_valid -> next cycle IDLE, all RAM 00, cpu_reset=1, busy=0. Bytes before a SYNC_BYTE are ignored.
